// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: next-PC sequencer with stall/flush control and pending-redirect hold.
// Optional FETCH_PC_CTRL_PERF_EN adds redirect and PC-hold counters.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter logic [31:0] INSTR_BYTES = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    input  logic        imem_ready,
    input  logic        stall_hz,
    input  logic        br_taken_e,
    input  logic [31:0] br_target_e,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        flush_d,
    output logic        flush_e,
    output logic        misalign,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
    state_t state, state_nx;
    logic [31:0] pend_pc, tgt, tgt_al;
    logic redir;
    // In PEND decode is already flushed, so only an execute branch can redirect.
    assign redir  = (state == RUN) ? (br_taken_e || (jump_d && !stall_hz)) : (state == PEND) && br_taken_e;
    assign tgt    = br_taken_e ? br_target_e : jump_target_d;
    assign tgt_al = {tgt[31:2], 2'b00};
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= BOOT;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst)
        if (!rst) pend_pc <= RESET_PC;
        else if (redir && !imem_ready) pend_pc <= tgt_al;
    always_comb begin
        state_nx = (state == BOOT || imem_ready) ? RUN : (redir || state == PEND) ? PEND : RUN;
    end
    always_comb begin
        pc_next  = (state == BOOT) ? RESET_PC : redir ? tgt_al : (state == PEND) ? pend_pc : stall_hz ? pc_f : pc_f + INSTR_BYTES;
        pc_en    = (state != BOOT) && imem_ready && (redir || state == PEND || !stall_hz);
        flush_d  = redir;
        flush_e  = redir && br_taken_e;
        misalign = redir && |tgt[1:0];
    end
`ifdef FETCH_PC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            redirect_cnt <= redirect_cnt + {31'd0, flush_d};
            stall_cnt    <= stall_cnt + {31'd0, (state != BOOT) && !pc_en};
        end
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed vector table, counter sequence and randomized run
// checked against a queue-based reference model of fetch_pc_ctrl.
module tb_fetch_pc_ctrl;
    localparam logic [31:0] RPC = 32'hBFC0_0000;
    logic clk = 0, rst = 0;
    logic [31:0] pc_f = RPC, br_target_e = 0, jump_target_d = 0;
    logic imem_ready = 0, stall_hz = 0, br_taken_e = 0, jump_d = 0;
    logic [31:0] pc_next, redirect_cnt, stall_cnt;
    logic pc_en, flush_d, flush_e, misalign;
    int n_cmp = 0, n_bad = 0;
    fetch_pc_ctrl dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .imem_ready(imem_ready), .stall_hz(stall_hz),
        .br_taken_e(br_taken_e), .br_target_e(br_target_e), .jump_d(jump_d),
        .jump_target_d(jump_target_d), .pc_next(pc_next), .pc_en(pc_en), .flush_d(flush_d),
        .flush_e(flush_e), .misalign(misalign), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic r; logic [31:0] pf; logic rdy, st, br; logic [31:0] bt; logic jd; logic [31:0] jt;
        logic [31:0] np; logic en, fd, fe, mis;
    } vec_t;
    vec_t tbl[$];
    // reference model: boot flag, queue of at most one pending target, PC register image
    logic m_boot = 1, p_rst = 0, started = 0;
    logic [31:0] pend_q[$];
    logic [31:0] m_rc = 0, m_sc = 0, mpc = RPC;
    logic [31:0] e_np, e_rc, e_sc;
    logic e_en, e_fd, e_fe, e_mis;
    task automatic commit;
        if (!p_rst) begin
            m_boot = 1; pend_q.delete(); m_rc = 0; m_sc = 0;
        end else if (m_boot) m_boot = 0;
        else begin
            m_rc = m_rc + (e_fd ? 32'd1 : 32'd0);
            m_sc = m_sc + (e_en ? 32'd0 : 32'd1);
            if (e_en) pend_q.delete();
            else if (e_fd) begin pend_q.delete(); pend_q.push_back(e_np); end
        end
        mpc = !p_rst ? RPC : e_en ? e_np : mpc;
    endtask
    task automatic evaluate;
        logic tb_, tj;
        logic [31:0] t;
        {e_np, e_en, e_fd, e_fe, e_mis} = {RPC, 4'b0};
        if (rst && !m_boot) begin
            tb_ = br_taken_e;
            tj = jump_d && !stall_hz && pend_q.size() == 0;
            t = tb_ ? br_target_e : jump_target_d;
            if (tb_ || tj) begin
                e_np = t & 32'hFFFF_FFFC; e_en = imem_ready; e_fd = 1; e_fe = tb_; e_mis = (t % 4) != 0;
            end else if (pend_q.size() != 0) begin
                e_np = pend_q[0]; e_en = imem_ready;
            end else if (stall_hz) e_np = pc_f;
            else begin
                e_np = pc_f + 32'd4; e_en = imem_ready;
            end
        end
`ifdef FETCH_PC_CTRL_PERF_EN
        e_rc = rst ? m_rc : 0; e_sc = rst ? m_sc : 0;
`else
        e_rc = 0; e_sc = 0;
`endif
    endtask
    task automatic drive(input logic r, input logic [31:0] pf, input logic rdy, st, br,
                         input logic [31:0] bt, input logic jd, input logic [31:0] jt);
        @(negedge clk);
        if (started) commit();
        started = 1;
        rst = r; pc_f = pf; imem_ready = rdy; stall_hz = st; br_taken_e = br;
        br_target_e = bt; jump_d = jd; jump_target_d = jt;
        p_rst = r;
        #2 evaluate();
    endtask
    task automatic check(input string nm, input logic [31:0] np, input logic en, fd, fe, mis);
        n_cmp++;
        if ({pc_next, pc_en, flush_d, flush_e, misalign} !== {np, en, fd, fe, mis}) begin
            n_bad++;
            $display("FAIL %s @%0t: got pc_next=%h en=%b fd=%b fe=%b mis=%b, want pc_next=%h en=%b fd=%b fe=%b mis=%b",
                     nm, $time, pc_next, pc_en, flush_d, flush_e, misalign, np, en, fd, fe, mis);
        end
    endtask
    task automatic check_cnt(input string nm, input logic [31:0] rc, sc);
        n_cmp++;
        if ({redirect_cnt, stall_cnt} !== {rc, sc}) begin
            n_bad++;
            $display("FAIL %s @%0t: got redirect_cnt=%0d stall_cnt=%0d, want %0d %0d", nm, $time, redirect_cnt, stall_cnt, rc, sc);
        end
    endtask
    function automatic vec_t v(logic r, logic [31:0] pf, logic rdy, st, br, logic [31:0] bt, logic jd, logic [31:0] jt,
                               logic [31:0] np, logic en, fd, fe, mis);
        vec_t x;
        x.r = r; x.pf = pf; x.rdy = rdy; x.st = st; x.br = br; x.bt = bt; x.jd = jd; x.jt = jt;
        x.np = np; x.en = en; x.fd = fd; x.fe = fe; x.mis = mis;
        return x;
    endfunction
    initial begin
        tbl.push_back(v(0, RPC, 1, 0, 0, 0, 0, 0, RPC, 0, 0, 0, 0));
        tbl.push_back(v(1, RPC, 1, 1, 1, 32'h123, 1, 32'h456, RPC, 0, 0, 0, 0));
        tbl.push_back(v(1, RPC, 1, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'hBFC0_0004, 1, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h100, 1, 1, 1, 32'h200, 0, 0, 32'h200, 1, 1, 1, 0));
        tbl.push_back(v(1, 32'h200, 1, 1, 0, 0, 1, 32'h300, 32'h200, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h200, 1, 0, 0, 0, 1, 32'h300, 32'h300, 1, 1, 0, 0));
        tbl.push_back(v(1, 32'h300, 0, 0, 1, 32'h400, 0, 0, 32'h400, 0, 1, 1, 0));
        tbl.push_back(v(1, 32'h300, 0, 1, 0, 0, 1, 32'h700, 32'h400, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h300, 0, 0, 0, 0, 0, 0, 32'h400, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h300, 1, 0, 0, 0, 0, 0, 32'h400, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h400, 0, 0, 1, 32'h600, 0, 0, 32'h600, 0, 1, 1, 0));
        tbl.push_back(v(1, 32'h400, 0, 0, 1, 32'h500, 0, 0, 32'h500, 0, 1, 1, 0));
        tbl.push_back(v(1, 32'h400, 1, 0, 0, 0, 0, 0, 32'h500, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h500, 1, 0, 1, 32'h206, 0, 0, 32'h204, 1, 1, 1, 1));
        tbl.push_back(v(1, 32'h204, 1, 0, 0, 0, 0, 0, 32'h208, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h4, 0, 0, 1, 32'h800, 0, 0, 32'h800, 0, 1, 1, 0));
        tbl.push_back(v(1, 32'h4, 1, 0, 1, 32'h901, 0, 0, 32'h900, 1, 1, 1, 1));
        tbl.push_back(v(1, 32'h900, 1, 0, 0, 0, 0, 0, 32'h904, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h904, 0, 0, 1, 32'hA00, 0, 0, 32'hA00, 0, 1, 1, 0));
        tbl.push_back(v(0, 32'h904, 1, 0, 0, 0, 0, 0, RPC, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h904, 1, 0, 0, 0, 0, 0, RPC, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h904, 1, 0, 0, 0, 0, 0, 32'h908, 1, 0, 0, 0));
        tbl.push_back(v(1, 32'h908, 0, 0, 0, 0, 1, 32'hB02, 32'hB00, 0, 1, 0, 1));
        tbl.push_back(v(1, 32'h908, 1, 0, 0, 0, 0, 0, 32'hB00, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].pf, tbl[i].rdy, tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].jd, tbl[i].jt);
            check($sformatf("vec%0d", i), tbl[i].np, tbl[i].en, tbl[i].fd, tbl[i].fe, tbl[i].mis);
            check_cnt($sformatf("vec%0d_cnt", i), e_rc, e_sc);
        end
        // counter sequence: reset, boot, two redirects, three stalls, then read back
        drive(0, RPC, 1, 0, 0, 0, 0, 0);
        drive(1, RPC, 1, 0, 0, 0, 0, 0);
        drive(1, RPC, 1, 0, 1, 32'h40, 0, 0);
        check("cnt_br", e_np, e_en, e_fd, e_fe, e_mis);
        drive(1, 32'h40, 1, 0, 0, 0, 1, 32'h80);
        check("cnt_j", e_np, e_en, e_fd, e_fe, e_mis);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h80, 1, 1, 0, 0, 0, 0);
            check("cnt_stall", 32'h80, 0, 0, 0, 0);
        end
        drive(1, 32'h80, 1, 0, 0, 0, 0, 0);
`ifdef FETCH_PC_CTRL_PERF_EN
        check_cnt("cnt_total", 32'd2, 32'd3);
`else
        check_cnt("cnt_total", 32'd0, 32'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(49, 0) != 0, ($urandom_range(7, 0) == 0) ? $urandom : mpc,
                  $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 25, $urandom_range(99, 0) < 15,
                  $urandom, $urandom_range(99, 0) < 20, $urandom);
            check("rand", e_np, e_en, e_fd, e_fe, e_mis);
            check_cnt("rand_cnt", e_rc, e_sc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
